// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder.
// Operands are consumed LSB first, one bit per clock, through a single
// full-adder cell (two half-adders plus an OR). The result is published
// on sum/carry_out only when the last bit has been produced, so those
// outputs always show the most recent complete result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] augend,
  input  logic [WIDTH-1:0] addend,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  // Six bits cover bit indices up to 63, enough for every legal WIDTH.
  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [5:0]       cnt_q, cnt_d;

  // Full-adder cell built from two half-adder stages.
  logic ha1_s, ha1_c, ha2_s, ha2_c, bit_s, bit_c;
  assign ha1_s = a_q[0] ^ b_q[0];
  assign ha1_c = a_q[0] & b_q[0];
  assign ha2_s = ha1_s ^ c_q;
  assign ha2_c = ha1_s & c_q;
  assign bit_s = ha2_s;
  assign bit_c = ha1_c | ha2_c;

  // State and datapath registers; reset wipes everything, including any
  // half-finished result, so nothing partial ever leaks out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: load on accept, shift one bit per SHIFT cycle,
  // publish the completed sum on the edge that enters DONE.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    ps_d   = ps_q;
    sum_d  = sum_q;
    c_d    = c_q;
    cout_d = cout_q;
    cnt_d  = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = augend;
          b_d   = addend;
          c_d   = carry_in;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        ps_d  = {bit_s, ps_q[WIDTH-1:1]};
        c_d   = bit_c;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) begin
          sum_d  = {bit_s, ps_q[WIDTH-1:1]};
          cout_d = bit_c;
        end
      end
      default: ;
    endcase
  end

  // Outputs are decoded from state or taken straight from registers.
  always_comb begin
    busy      = (state_q == SHIFT);
    done      = (state_q == DONE);
    sum       = sum_q;
    carry_out = cout_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder (WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_adder;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] augend = '0;
  logic [W-1:0] addend = '0;
  logic         carry_in = 1'b0;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         carry_out;

  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_co  = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .augend(augend), .addend(addend), .carry_in(carry_in),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one operation from a falling edge in IDLE; returns at the falling
  // edge of the IDLE cycle following DONE, ready for a back-to-back start.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic [W-1:0] es, input logic eco);
    int busy_n, done_n, done_at;
    logic [W-1:0] got_s;
    logic got_c;
    busy_n = 0; done_n = 0; done_at = 0; got_s = '0; got_c = 1'b0;
    start = 1'b1; augend = a; addend = b; carry_in = ci;
    for (int i = 1; i <= W + 2; i++) begin
      @(negedge clock);
      if (i == 1) begin
        start = 1'b0;
        augend = W'($urandom); addend = W'($urandom); carry_in = 1'($urandom);
        chk("held_sum", 32'(sum), 32'(prev_sum));
        chk("held_co", 32'(carry_out), 32'(prev_co));
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = i;
      end
      if (i == W + 1) begin got_s = sum; got_c = carry_out; end
    end
    chk("busy_cycles", 32'(busy_n), 32'(W));
    chk("done_latency", 32'(done_at), 32'(W + 1));
    chk("done_pulses", 32'(done_n), 32'd1);
    chk("sum", 32'(got_s), 32'(es));
    chk("carry_out", 32'(got_c), 32'(eco));
    prev_sum = es; prev_co = eco;
  endtask

  initial begin : main
    logic [W:0] e;
    logic [W:0] q[$];
    logic [W-1:0] ra, rb;
    logic rc;
    int dn, last;

    // Reset applied before any clock edge must clear outputs at once.
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_co", 32'(carry_out), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    // Directed vectors, start accepted on the first edge after release.
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Start held high with operands changing every cycle: only those
    // present in IDLE cycles are used, one done every W+2 cycles.
    dn = 0; last = -1;
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        e = (q.size() != 0) ? q.pop_front() : '0;
        chk("cont_sum", 32'(sum), 32'(e[W-1:0]));
        chk("cont_co", 32'(carry_out), 32'(e[W]));
        if (last >= 0) chk("cont_period", 32'(c - last), 32'(W + 2));
        last = c; dn++;
        prev_sum = e[W-1:0]; prev_co = e[W];
      end
      augend = W'(c * 37 + 5); addend = W'(c * 91 + 3); carry_in = 1'(c);
      if (!busy && !done) q.push_back({1'b0, augend} + {1'b0, addend} + (W+1)'(carry_in));
      @(negedge clock);
    end
    start = 1'b0;
    chk("cont_dones", 32'(dn), 32'd4);
    @(negedge clock);

    // Reset between edges, four cycles into an operation.
    start = 1'b1; augend = 8'hFF; addend = 8'hFF; carry_in = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_co", 32'(carry_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done || busy) dn++;
    end
    chk("no_done_after_rst", 32'(dn), 32'd0);
    prev_sum = '0; prev_co = 1'b0;
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Random back-to-back operations against the integer model.
    for (int k = 0; k < 1000; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      e = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      run_op(ra, rb, rc, e[W-1:0], e[W]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
